// File: rtl/pc_gen_if.sv
// Fetch-PC control bus: hazard/execute/decode inputs toward the PC
// generator, and the generator's PC and RAS status back out.
interface pc_gen_if #(
  parameter int XLEN = 64
);
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            trap;
  logic [XLEN-1:0] trap_vec;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_next;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_hit;

  // Driver side (pipeline control / testbench)
  modport master (
    output stall, redirect, redirect_pc, trap, trap_vec, ras_push, ras_pop,
    input  pc_out, pc_next, ras_empty, ras_full, ras_hit
  );

  // PC generator side
  modport slave (
    input  stall, redirect, redirect_pc, trap, trap_vec, ras_push, ras_pop,
    output pc_out, pc_next, ras_empty, ras_full, ras_hit
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter with a circular return-address stack.
// Next-PC priority: reset, trap, redirect, stall hold, RAS pop, PC+INC.
module pc_gen #(
  parameter int          XLEN      = 64,
  parameter logic [63:0] RESET_VEC = 64'h0,
  parameter int          INC       = 4,
  parameter int          DEPTH     = 4
) (
  input logic     clk,
  input logic     reset,
  pc_gen_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ras [DEPTH];
  logic [PW-1:0]   r_top;
  logic [PW:0]     r_cnt;

  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_next;
  logic            w_adv;
  logic            w_nonempty;
  logic            w_hit;
  logic [PW-1:0]   w_top_inc;
  logic [PW-1:0]   w_top_dec;
  logic            w_ras_we;
  logic [PW-1:0]   w_ras_wa;
  logic [PW-1:0]   w_top_nxt;
  logic [PW:0]     w_cnt_nxt;

  // Next-PC selection; stack is only consulted when nothing higher-priority fires
  always_comb begin
    w_seq      = r_pc + XLEN'(INC);
    w_adv      = !bus.trap && !bus.redirect && !bus.stall;
    w_nonempty = (r_cnt != '0);
    w_hit      = w_adv && bus.ras_pop && w_nonempty;
    w_top_inc  = r_top + PW'(1);
    w_top_dec  = r_top - PW'(1);
    if (bus.trap)          w_next = bus.trap_vec;
    else if (bus.redirect) w_next = bus.redirect_pc;
    else if (bus.stall)    w_next = r_pc;
    else if (w_hit)        w_next = r_ras[r_top];
    else                   w_next = w_seq;
  end

  // RAS pointer/count/write control; push+pop on a non-empty stack swaps the top in place
  always_comb begin
    w_ras_we  = 1'b0;
    w_ras_wa  = r_top;
    w_top_nxt = r_top;
    w_cnt_nxt = r_cnt;
    if (bus.trap) begin
      w_top_nxt = '0;
      w_cnt_nxt = '0;
    end else if (w_adv) begin
      if (bus.ras_push && bus.ras_pop && w_nonempty) begin
        w_ras_we = 1'b1;
      end else if (bus.ras_push) begin
        // When full this lands on the oldest entry, overwriting it
        w_ras_we  = 1'b1;
        w_ras_wa  = w_top_inc;
        w_top_nxt = w_top_inc;
        if (r_cnt != CNT_FULL) w_cnt_nxt = r_cnt + (PW+1)'(1);
      end else if (bus.ras_pop && w_nonempty) begin
        w_top_nxt = w_top_dec;
        w_cnt_nxt = r_cnt - (PW+1)'(1);
      end
    end
  end

  // PC and stack bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= XLEN'(RESET_VEC);
      r_top <= '0;
      r_cnt <= '0;
    end else begin
      r_pc  <= w_next;
      r_top <= w_top_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Stack storage; contents need no reset since they are read only when count>0
  always_ff @(posedge clk) begin
    if (!reset && w_ras_we) r_ras[w_ras_wa] <= w_seq;
  end

  assign bus.pc_out    = r_pc;
  assign bus.pc_next   = w_next;
  assign bus.ras_empty = (r_cnt == '0);
  assign bus.ras_full  = (r_cnt == CNT_FULL);
  assign bus.ras_hit   = w_hit;
endmodule

// File: tb/tb_pc_gen.sv
// Directed test of pc_gen: sequencing, stall/redirect, RAS push/pop/overflow,
// push+pop swap, trap clearing and reset priority.
module tb_pc_gen;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(64)) bus ();

  pc_gen #(
    .XLEN(64), .RESET_VEC(64'h1000), .INC(4), .DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.redirect = 0; bus.trap = 0;
    bus.ras_push = 0; bus.ras_pop = 0;
  endtask

  task automatic jump(input logic [63:0] tgt);
    idle();
    bus.redirect = 1; bus.redirect_pc = tgt;
    step();
    idle();
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] exp);
    idle();
    bus.ras_pop = 1;
    #1;
    chk({tag, "_next"}, bus.pc_next, exp);
    chk({tag, "_hit"}, 64'(bus.ras_hit), 64'd1);
    step();
    idle();
  endtask

  initial begin
    idle();
    bus.redirect_pc = '0; bus.trap_vec = '0;
    reset = 1;
    step();
    reset = 0;
    chk("rst_pc", bus.pc_out, 64'h1000);
    chk("rst_empty", 64'(bus.ras_empty), 64'd1);
    chk("rst_full", 64'(bus.ras_full), 64'd0);

    step(); chk("seq1", bus.pc_out, 64'h1004);
    step(); chk("seq2", bus.pc_out, 64'h1008);
    chk("seq_empty", 64'(bus.ras_empty), 64'd1);

    // Stall twice, redirect arriving on the second stall cycle
    bus.stall = 1;
    step(); chk("stall_hold", bus.pc_out, 64'h1008);
    bus.redirect = 1; bus.redirect_pc = 64'h2000;
    #1; chk("stall_redir_next", bus.pc_next, 64'h2000);
    step(); chk("stall_redir", bus.pc_out, 64'h2000);
    idle();

    // Three calls at 0x100/0x200/0x300, then three returns
    jump(64'h100); bus.ras_push = 1; step();
    jump(64'h200); bus.ras_push = 1; step();
    jump(64'h300); bus.ras_push = 1; step(); idle();
    chk("push3_pc", bus.pc_out, 64'h304);
    pop_chk("pop1", 64'h304);
    pop_chk("pop2", 64'h204);
    pop_chk("pop3", 64'h104);
    chk("pop_empty", 64'(bus.ras_empty), 64'd1);
    bus.ras_pop = 1;
    #1;
    chk("pop4_next", bus.pc_next, 64'h108);
    chk("pop4_hit", 64'(bus.ras_hit), 64'd0);
    step(); idle();
    chk("pop4_pc", bus.pc_out, 64'h108);

    // Overflow: five calls from 0x108 push 0x10C..0x11C; 0x10C is lost
    bus.ras_push = 1;
    repeat (5) step();
    idle();
    chk("ovf_full", 64'(bus.ras_full), 64'd1);
    jump(64'h4000);
    pop_chk("ovf_pop1", 64'h11C);
    pop_chk("ovf_pop2", 64'h118);
    pop_chk("ovf_pop3", 64'h114);
    pop_chk("ovf_pop4", 64'h110);
    chk("ovf_empty", 64'(bus.ras_empty), 64'd1);

    // Push+pop swap: top 0x104, swap at 0x500
    jump(64'h100); bus.ras_push = 1; step();
    jump(64'h500);
    bus.ras_push = 1; bus.ras_pop = 1;
    #1; chk("swap_next", bus.pc_next, 64'h104);
    step(); idle();
    chk("swap_pc", bus.pc_out, 64'h104);
    chk("swap_nonempty", 64'(bus.ras_empty), 64'd0);
    pop_chk("swap_top", 64'h504);
    chk("swap_cnt1", 64'(bus.ras_empty), 64'd1);

    // Trap beats redirect and pop, and clears the stack
    bus.ras_push = 1; step(); idle();
    chk("trap_pre", 64'(bus.ras_empty), 64'd0);
    bus.trap = 1; bus.trap_vec = 64'h8000;
    bus.redirect = 1; bus.redirect_pc = 64'h2000; bus.ras_pop = 1;
    #1; chk("trap_next", bus.pc_next, 64'h8000);
    chk("trap_hit", 64'(bus.ras_hit), 64'd0);
    step();
    chk("trap_pc", bus.pc_out, 64'h8000);
    chk("trap_empty", 64'(bus.ras_empty), 64'd1);
    reset = 1;
    step();
    reset = 0; idle();
    chk("rst_trap_pc", bus.pc_out, 64'h1000);

    // Silent wrap of the sequential increment
    jump(64'hFFFF_FFFF_FFFF_FFFC);
    step(); chk("wrap", bus.pc_out, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
